// File: rtl/traffic_phase_ctrl.sv
// Main/side junction sequencer with pedestrian phase, latched requests and
// a flashing-amber fault mode. All outputs are registered.
module traffic_phase_ctrl #(
  parameter int unsigned TICK_DIV   = 50_000_000,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned T_GREEN_M  = 30,
  parameter int unsigned T_YELLOW   = 3,
  parameter int unsigned T_ALLRED   = 1,
  parameter int unsigned T_GREEN_S  = 15,
  parameter int unsigned T_WALK     = 10,
  parameter int unsigned FLASH_HALF = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       side_req,
  input  logic       walk_req,
  input  logic       flash_en,
  output logic [6:0] lights,
  output logic [2:0] phase,
  output logic       walk_ack
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PrescMax = PW'(TICK_DIV - 1);

  // A programmed duration of zero behaves as one tick.
  function automatic logic [CNT_W-1:0] dur_of(input int unsigned t);
    return (t == 0) ? CNT_W'(1) : CNT_W'(t);
  endfunction

  localparam logic [CNT_W-1:0] DurGreenM = dur_of(T_GREEN_M);
  localparam logic [CNT_W-1:0] DurYellow = dur_of(T_YELLOW);
  localparam logic [CNT_W-1:0] DurAllRed = dur_of(T_ALLRED);
  localparam logic [CNT_W-1:0] DurGreenS = dur_of(T_GREEN_S);
  localparam logic [CNT_W-1:0] DurWalk   = dur_of(T_WALK);
  localparam logic [CNT_W-1:0] DurFlash  = dur_of(FLASH_HALF);

  typedef enum logic [2:0] {
    StMainGreen  = 3'd0,
    StMainYellow = 3'd1,
    StAllRed1    = 3'd2,
    StSideGreen  = 3'd3,
    StSideYellow = 3'd4,
    StAllRed2    = 3'd5,
    StWalk       = 3'd6,
    StFlash      = 3'd7
  } state_e;

  // Bit order {Rm, Ym, Gm, Rs, Ys, Gs, W}.
  function automatic logic [6:0] decode(input state_e st, input logic flash_on);
    case (st)
      StMainGreen:  return 7'b0011000;
      StMainYellow: return 7'b0101000;
      StAllRed1:    return 7'b1001000;
      StSideGreen:  return 7'b1000010;
      StSideYellow: return 7'b1000100;
      StAllRed2:    return 7'b1001000;
      StWalk:       return 7'b1001001;
      default:      return flash_on ? 7'b0100100 : 7'b0000000;
    endcase
  endfunction

  state_e           state_q, state_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             flash_on_q, flash_on_d;
  logic             side_pend_q, side_pend_d;
  logic             walk_pend_q, walk_pend_d;
  logic [6:0]       lights_q;
  logic             walk_ack_q;
  logic [CNT_W-1:0] dur;
  logic             tick;
  logic             expire;
  logic             restart;

  assign tick = (presc_q == PrescMax);

  // Duration of the current phase; the timer saturates at it so that an
  // expired main green stays expired while it waits for a request.
  always_comb begin
    dur = DurAllRed;
    case (state_q)
      StMainGreen:                dur = DurGreenM;
      StMainYellow, StSideYellow: dur = DurYellow;
      StSideGreen:                dur = DurGreenS;
      StWalk:                     dur = DurWalk;
      StFlash:                    dur = DurFlash;
      default:                    dur = DurAllRed;
    endcase
  end

  // Expiry looks one tick ahead so the phase ends exactly on its last clock.
  assign expire = (timer_q == dur) || (tick && (timer_q == dur - CNT_W'(1)));

  // Next-state, flash toggle, timing and request latch logic.
  always_comb begin
    state_d    = state_q;
    flash_on_d = flash_on_q;
    restart    = 1'b0;
    case (state_q)
      StMainGreen:  if (expire && (side_pend_q || walk_pend_q)) state_d = StMainYellow;
      StMainYellow: if (expire) state_d = StAllRed1;
      StAllRed1:    if (expire) state_d = side_pend_q ? StSideGreen : StWalk;
      StSideGreen:  if (expire) state_d = StSideYellow;
      StSideYellow: if (expire) state_d = StAllRed2;
      StAllRed2:    if (expire) state_d = walk_pend_q ? StWalk : StMainGreen;
      StWalk:       if (expire) state_d = StMainGreen;
      default: begin
        if (!flash_en) begin
          state_d = StAllRed2;
        end else if (expire) begin
          flash_on_d = ~flash_on_q;
          restart    = 1'b1;
        end
      end
    endcase
    if (flash_en && (state_q != StFlash)) begin
      state_d    = StFlash;
      flash_on_d = 1'b1;
    end
    if (state_d != state_q) restart = 1'b1;

    presc_d = presc_q + PW'(1);
    timer_d = timer_q;
    if (restart) begin
      presc_d = '0;
      timer_d = '0;
    end else if (tick) begin
      presc_d = '0;
      if (timer_q != dur) timer_d = timer_q + CNT_W'(1);
    end

    // Entry into the serving state wins over a coincident request.
    side_pend_d = side_pend_q | side_req;
    if ((state_d == StSideGreen) && (state_q != StSideGreen)) side_pend_d = 1'b0;
    walk_pend_d = walk_pend_q | walk_req;
    if ((state_d == StWalk) && (state_q != StWalk)) walk_pend_d = 1'b0;
  end

  // State, timers, latches and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StAllRed2;
      presc_q     <= '0;
      timer_q     <= '0;
      flash_on_q  <= 1'b0;
      side_pend_q <= 1'b0;
      walk_pend_q <= 1'b0;
      lights_q    <= 7'b1001000;
      walk_ack_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      timer_q     <= timer_d;
      flash_on_q  <= flash_on_d;
      side_pend_q <= side_pend_d;
      walk_pend_q <= walk_pend_d;
      lights_q    <= decode(state_d, flash_on_d);
      walk_ack_q  <= ~walk_pend_q & walk_pend_d;
    end
  end

  assign lights   = lights_q;
  assign phase    = state_q;
  assign walk_ack = walk_ack_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed bench for traffic_phase_ctrl with short tick and phase durations.
module tb_traffic_phase_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       side_req;
  logic       walk_req;
  logic       flash_en;
  logic [6:0] lights;
  logic [2:0] phase;
  logic       walk_ack;

  int total = 0;
  int bad   = 0;

  localparam logic [6:0] LMg  = 7'b0011000;
  localparam logic [6:0] LMy  = 7'b0101000;
  localparam logic [6:0] LAr  = 7'b1001000;
  localparam logic [6:0] LSg  = 7'b1000010;
  localparam logic [6:0] LSy  = 7'b1000100;
  localparam logic [6:0] LWk  = 7'b1001001;
  localparam logic [6:0] LFon = 7'b0100100;
  localparam logic [6:0] LFof = 7'b0000000;

  traffic_phase_ctrl #(
    .TICK_DIV  (4),
    .CNT_W     (8),
    .T_GREEN_M (3),
    .T_YELLOW  (2),
    .T_ALLRED  (1),
    .T_GREEN_S (2),
    .T_WALK    (2),
    .FLASH_HALF(1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .side_req(side_req),
    .walk_req(walk_req),
    .flash_en(flash_en),
    .lights  (lights),
    .phase   (phase),
    .walk_ack(walk_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (lights,phase,ack) at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one edge and sample just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [6:0] lt, input logic [2:0] ph,
                           input logic ack);
    check(tag, {21'd0, lights, phase, walk_ack}, {21'd0, lt, ph, ack});
  endtask

  // Expect n consecutive samples of one phase, ending on the following edge.
  task automatic hold(input string tag, input logic [6:0] lt, input logic [2:0] ph,
                      input int n);
    for (int i = 0; i < n; i++) begin
      check_out(tag, lt, ph, 1'b0);
      step();
    end
  endtask

  task automatic side_cycle(input string tag);
    hold({tag, "_my"}, LMy, 3'd1, 8);
    hold({tag, "_ar1"}, LAr, 3'd2, 4);
    hold({tag, "_sg"}, LSg, 3'd3, 8);
    hold({tag, "_sy"}, LSy, 3'd4, 8);
    hold({tag, "_ar2"}, LAr, 3'd5, 4);
  endtask

  initial begin
    rst = 1'b1; side_req = 1'b0; walk_req = 1'b0; flash_en = 1'b0;
    step();
    step();

    // 1: reset state, then all-red for one tick, then main green holds.
    check_out("s1_rst", LAr, 3'd5, 1'b0);
    rst = 1'b0;
    hold("s1_ar2", LAr, 3'd5, 4);
    hold("s1_mg", LMg, 3'd0, 100);

    // 2: one-cycle side request long after main green expired.
    side_req = 1'b1;
    step();
    side_req = 1'b0;
    check_out("s2_latch", LMg, 3'd0, 1'b0);
    step();
    side_cycle("s2");
    check_out("s2_back", LMg, 3'd0, 1'b0);

    // 3: early request; main green still lasts its 12 clocks.
    step();
    step();
    side_req = 1'b1;
    step();
    side_req = 1'b0;
    hold("s3_mg", LMg, 3'd0, 9);
    side_cycle("s3");
    check_out("s3_back", LMg, 3'd0, 1'b0);

    // 4: side and walk pending; single ack, then side sequence and walk.
    side_req = 1'b1; walk_req = 1'b1;
    step();
    side_req = 1'b0; walk_req = 1'b0;
    check_out("s4_ack", LMg, 3'd0, 1'b1);
    step();
    check_out("s4_ack_lo", LMg, 3'd0, 1'b0);
    walk_req = 1'b1;
    step();
    walk_req = 1'b0;
    check_out("s4_noack", LMg, 3'd0, 1'b0);
    step();
    hold("s4_mg", LMg, 3'd0, 8);
    side_cycle("s4");
    hold("s4_walk", LWk, 3'd6, 8);
    check_out("s4_back", LMg, 3'd0, 1'b0);

    // 5: flash during side green, walk pending across flash.
    side_req = 1'b1;
    step();
    side_req = 1'b0;
    hold("s5_mg", LMg, 3'd0, 11);
    hold("s5_my", LMy, 3'd1, 8);
    hold("s5_ar1", LAr, 3'd2, 4);
    check_out("s5_sg", LSg, 3'd3, 1'b0);
    walk_req = 1'b1;
    step();
    walk_req = 1'b0;
    check_out("s5_ack", LSg, 3'd3, 1'b1);
    flash_en = 1'b1;
    step();
    hold("s5_on", LFon, 3'd7, 4);
    hold("s5_off", LFof, 3'd7, 4);
    hold("s5_on2", LFon, 3'd7, 4);
    check_out("s5_off2", LFof, 3'd7, 1'b0);
    flash_en = 1'b0;
    step();
    hold("s5_ar2", LAr, 3'd5, 4);
    hold("s5_walk", LWk, 3'd6, 8);
    check_out("s5_back", LMg, 3'd0, 1'b0);

    // 6: reset in the middle of walk clears pends and suppresses ack.
    walk_req = 1'b1;
    step();
    walk_req = 1'b0;
    check_out("s6_ack", LMg, 3'd0, 1'b1);
    step();
    hold("s6_mg", LMg, 3'd0, 10);
    hold("s6_my", LMy, 3'd1, 8);
    hold("s6_ar1", LAr, 3'd2, 4);
    hold("s6_walk", LWk, 3'd6, 2);
    side_req = 1'b1;
    step();
    side_req = 1'b0;
    check_out("s6_walk3", LWk, 3'd6, 1'b0);
    rst = 1'b1; walk_req = 1'b1;
    step();
    rst = 1'b0; walk_req = 1'b0;
    check_out("s6_rst", LAr, 3'd5, 1'b0);
    hold("s6_ar2", LAr, 3'd5, 4);
    hold("s6_mg_idle", LMg, 3'd0, 20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
